fifo_wr_arbiter: RTL

Write-side scheduler that shares the single write port of the asynchronous FIFO memory among NREQ requesters in the write clock domain. Round-robin arbitration with packet lock: once granted, a requester owns the port until it transfers a beat flagged last, so packets land contiguously in the FIFO. Drives the FIFO write enable and write data, and honours the FIFO full flag. Sits between producer logic and the FIFO write-pointer/memory pair.

---
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// ---------------------------------------------------------------------------
// Write-side scheduler for the asynchronous FIFO. NREQ producers in the write
// clock domain share the single FIFO write port. Arbitration is round-robin
// and packet-locked: once a requester is granted, it keeps the port until it
// transfers a beat flagged last. As a result, packets land contiguously.
//
// Ports
//   wr_clk     write-domain clock, rising edge
//   wr_rst_n   asynchronous active-low reset
//   req_valid  per-requester beat valid                    [NREQ]
//   req_last   per-requester last-beat flag (with valid)   [NREQ]
//   req_data   per-requester data, requester i at [i*DATASIZE +: DATASIZE]
//   req_ready  per-requester accept                         [NREQ]
//   full       FIFO full flag from the write-pointer logic
//   wr_en      FIFO write enable
//   wr_data    FIFO write data                              [DATASIZE]
//   grant      registered one-hot current owner             [NREQ]
//   busy       high while a packet is locked
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int DATASIZE = 8,
  parameter int NREQ     = 4
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     full,
  output logic                     wr_en,
  output logic [DATASIZE-1:0]      wr_data,
  output logic [NREQ-1:0]          grant,
  output logic                     busy
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;   // index of the last packet owner

  logic            found;
  logic [PW-1:0]   cand;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   owner_idx;

  // Round-robin search starting just after the last owner. The explicit
  // modulo keeps the rotation correct when NREQ is not a power of two.
  always_comb begin
    // NOTE: every variable written here gets a default first; otherwise a
    // path that leaves it unassigned would infer a latch.
    found   = 1'b0;
    cand    = '0;
    win_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Binary index of the current owner (grant_q is one-hot or zero).
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) owner_idx = PW'(i);
    end
  end

  // Write-port steering. This is driven only from registered state plus full,
  // so there is no combinational path from req_valid to req_ready.
  always_comb begin
    req_ready = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    if (state_q == LOCK) begin
      req_ready[owner_idx] = !full;
      wr_en                = req_valid[owner_idx] && !full;
      wr_data              = req_data[int'(owner_idx)*DATASIZE +: DATASIZE];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d          = LOCK;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
        end
      end
      LOCK: begin
        // Only a completed packet releases the port and moves the pointer.
        if (wr_en && req_last[owner_idx]) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_idx;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Resetting rr_ptr to NREQ-1 gives requester 0 first priority.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PW'(NREQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the values from before the edge.
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == LOCK);

endmodule
